alu_rr_arbiter: RTL and testbench
=================================

Name: alu_rr_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the shared 16-bit combinational ALU.
- Accepts one operation (x, y, 3-bit opcode) at a time via valid/ready.
- Drives the ALU from registered operands, captures result and flags, and returns them to the owning requester via a response handshake.
- Sits between the datapath issue logic (requester 0) and the address/branch unit (requester 1).

Parameters:
- W, 16, operand/result width; must match the ALU.
- CNT_W, 16, width of the optional grant counters.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester accept; one-hot or zero
- req0_x, req1_x  in  W  operand x per requester
- req0_y, req1_y  in  W  operand y per requester
- req0_op, req1_op  in  3  opcode: 000 AND, 001 OR, 010 ADD, 011 SUB, 111 SLT
- resp_valid  out  2  per-requester response valid; one-hot or zero
- resp_ready  in  2  per-requester response accept
- resp_z  out  W  captured result
- resp_flags  out  4  {lt, eq, gt, overflow} captured from ALU
- resp_err  out  1  illegal opcode flag
- alu_x, alu_y  out  W  to ALU
- alu_c  out  3  to ALU
- alu_z  in  W  from ALU
- alu_lt, alu_eq, alu_gt, alu_ovf  in  1  from ALU

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, priority pointer=0.
  - All outputs 0: req_ready, resp_valid, resp_z, resp_flags, resp_err, alu_x, alu_y, alu_c.
- IDLE:
  - If any req_valid, grant per round-robin; the requester at the pointer wins ties.
  - req_ready[g] is asserted combinationally in this cycle only.
  - Latch x, y, op and owner g into registers, then go to EXEC.
  - If no req_valid, stay in IDLE.
- EXEC (1 cycle):
  - alu_x, alu_y and alu_c are driven from the latched registers.
  - At cycle end, register alu_z and the flags into resp_z/resp_flags, then go to RESP.
- Illegal opcode (100, 101, 110):
  - The ALU is not relied upon.
  - resp_z=0, resp_flags=0, resp_err=1.
  - All other opcodes set resp_err=0.
- RESP:
  - resp_valid[owner]=1. Hold resp_z, resp_flags and resp_err stable until resp_ready[owner].
  - On the handshake, the pointer moves to ~owner and state returns to IDLE.
  - resp_ready of the non-owner is ignored.
- ALU inputs hold their last value outside EXEC. They change only on a new grant.
- Latency and throughput:
  - Accept at cycle N gives resp_valid at N+2 earliest.
  - Back-to-back throughput is 1 op per 3 cycles.
  - A new request is never accepted while in EXEC or RESP.
- Simultaneous requests:
  - Both valid with pointer=0 gives grant order 0, 1, 0, 1...
  - A lone requester is granted every turn.
- Requester protocol: a requester may drop req_valid before ready. Nothing is latched and no grant is recorded.
- Reset mid-operation: any in-flight op is discarded, no response is issued, and the pointer returns to 0.

Optional Feature:
- Macro ALU_ARB_PERF_CNT_EN.
- When defined:
  - Adds outputs grant_cnt0 and grant_cnt1 (CNT_W each).
  - Each counter increments on its requester's accept handshake and saturates at all-ones.
  - Counters clear on rst.
- When undefined: these ports and counters are absent. Function is otherwise identical.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_AND=3'b000, OP_OR=3'b001, OP_ADD=3'b010, OP_SUB=3'b011, OP_SLT=3'b111;
  - the state encoding IDLE/EXEC/RESP;
  - the flag index constants.
- Sub-module rr_pick2: the 2-way round-robin grant from req_valid and the pointer. It is purely combinational and reusable.

Test Plan:
- Single op: after reset, req0 ADD x=0x0013, y=0x000B.
  - Expect req_ready=01 in the accept cycle and resp_valid=01 two cycles later.
  - resp_z=0x001E, flags gt=1, resp_err=0.
- Contention: both valid continuously, req0 SUB 4-3 and req1 AND 0x000B&0x0013.
  - Expect grant order 0, 1, 0, 1.
  - resp_z alternates 0x0001 and 0x0003, with each response on the correct resp_valid bit.
- Backpressure: resp_ready held 0 for 5 cycles.
  - resp_valid and resp_z stay stable.
  - req_ready stays 00 despite pending req1.
  - Release leads to IDLE and the req1 grant.
- SLT and illegal op:
  - req1 SLT 0x000B < 0x0013 gives resp_z=0x0001.
  - Op 3'b101 gives resp_z=0 and resp_err=1.
- Reset mid-op: assert rst during EXEC.
  - Expect no response issued and all outputs 0.
  - Next simultaneous request is granted to req0.
- With ALU_ARB_PERF_CNT_EN defined: 3 req0 ops and 2 req1 ops give grant_cnt0=3 and grant_cnt1=2. Preload near-max to confirm saturation at 0xFFFF.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU round-robin arbiter: opcodes, FSM states,
// and bit positions inside the 4-bit flag vector {lt, eq, gt, overflow}.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int FLAG_OVF = 0;
  localparam int FLAG_GT  = 1;
  localparam int FLAG_EQ  = 2;
  localparam int FLAG_LT  = 3;

  // 100/101/110 are unassigned; the ALU output is meaningless for them.
  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick. The requester named by ptr wins when both are
// active; a lone requester always wins. Purely combinational.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // one-hot grant, pointer side first
  always_comb begin
    gnt = 2'b00;
    if (req[ptr])       gnt[ptr]  = 1'b1;
    else if (req[~ptr]) gnt[~ptr] = 1'b1;
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational 16-bit ALU between
// the datapath issue logic (requester 0) and the address/branch unit
// (requester 1). One op in flight: IDLE (grant) -> EXEC -> RESP.
// Optional per-requester grant counters: define ALU_ARB_PERF_CNT_EN.
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int W     = 16,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [W-1:0]    req0_x,
  input  logic [W-1:0]    req1_x,
  input  logic [W-1:0]    req0_y,
  input  logic [W-1:0]    req1_y,
  input  logic [2:0]      req0_op,
  input  logic [2:0]      req1_op,
  output logic [1:0]      resp_valid,
  input  logic [1:0]      resp_ready,
  output logic [W-1:0]    resp_z,
  output logic [3:0]      resp_flags,
  output logic            resp_err,
  output logic [W-1:0]    alu_x,
  output logic [W-1:0]    alu_y,
  output logic [2:0]      alu_c,
  input  logic [W-1:0]    alu_z,
  input  logic            alu_lt,
  input  logic            alu_eq,
  input  logic            alu_gt,
  input  logic            alu_ovf
`ifdef ALU_ARB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`endif
);

  state_t     state, state_nxt;
  logic       ptr;      // requester that wins a tie
  logic       owner;    // requester whose op is in flight
  logic [1:0] gnt;
  logic       accept;
  logic       resp_hs;

  rr_pick2 u_pick (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt)
  );

  // next state plus handshake outputs; both handshakes are masked during rst
  always_comb begin
    state_nxt  = state;
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    accept     = 1'b0;
    resp_hs    = 1'b0;
    case (state)
      IDLE: begin
        if (|gnt && !rst) begin
          accept    = 1'b1;
          req_ready = gnt;
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (!rst) resp_valid[owner] = 1'b1;
        if (resp_ready[owner]) begin
          resp_hs   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state, pointer, ALU operand registers and captured response
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      owner      <= 1'b0;
      alu_x      <= '0;
      alu_y      <= '0;
      alu_c      <= 3'b000;
      resp_z     <= '0;
      resp_flags <= 4'b0000;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      // ALU inputs only move on a new grant, so they hold between ops
      if (accept) begin
        owner <= gnt[1];
        alu_x <= gnt[1] ? req1_x  : req0_x;
        alu_y <= gnt[1] ? req1_y  : req0_y;
        alu_c <= gnt[1] ? req1_op : req0_op;
      end
      if (state == EXEC) begin
        if (op_legal(alu_c)) begin
          resp_z               <= alu_z;
          resp_flags[FLAG_LT]  <= alu_lt;
          resp_flags[FLAG_EQ]  <= alu_eq;
          resp_flags[FLAG_GT]  <= alu_gt;
          resp_flags[FLAG_OVF] <= alu_ovf;
          resp_err             <= 1'b0;
        end else begin
          resp_z     <= '0;
          resp_flags <= 4'b0000;
          resp_err   <= 1'b1;
        end
      end
      if (resp_hs) ptr <= ~owner;
    end
  end

`ifdef ALU_ARB_PERF_CNT_EN
  // saturating per-requester accept counters
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (accept && gnt[0] && !(&grant_cnt0)) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (accept && gnt[1] && !(&grant_cnt1)) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with a behavioural 16-bit ALU attached.
// Inputs change just after the falling edge; outputs are sampled 1ns later.
module tb_alu_rr_arbiter;

  localparam int W     = 16;
  localparam int CNT_W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid, req_ready, resp_valid, resp_ready;
  logic [W-1:0]  req0_x, req1_x, req0_y, req1_y;
  logic [2:0]    req0_op, req1_op;
  logic [W-1:0]  resp_z, alu_x, alu_y, alu_z;
  logic [3:0]    resp_flags;
  logic          resp_err;
  logic [2:0]    alu_c;
  logic          alu_lt, alu_eq, alu_gt, alu_ovf;
`ifdef ALU_ARB_PERF_CNT_EN
  logic [CNT_W-1:0] grant_cnt0, grant_cnt1;
`endif

  int total = 0;
  int bad   = 0;

  alu_rr_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_x(req0_x), .req1_x(req1_x),
    .req0_y(req0_y), .req1_y(req1_y),
    .req0_op(req0_op), .req1_op(req1_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_z(resp_z), .resp_flags(resp_flags), .resp_err(resp_err),
    .alu_x(alu_x), .alu_y(alu_y), .alu_c(alu_c),
    .alu_z(alu_z), .alu_lt(alu_lt), .alu_eq(alu_eq), .alu_gt(alu_gt), .alu_ovf(alu_ovf)
`ifdef ALU_ARB_PERF_CNT_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in ALU: signed compare flags; illegal codes return junk so a
  // pass-through would show up.
  always_comb begin
    logic signed [W-1:0] sx, sy, sz;
    sx = alu_x; sy = alu_y;
    alu_z = '0; alu_ovf = 1'b0;
    alu_lt = sx < sy; alu_eq = sx == sy; alu_gt = sx > sy;
    case (alu_c)
      3'b000: alu_z = alu_x & alu_y;
      3'b001: alu_z = alu_x | alu_y;
      3'b010: begin sz = sx + sy; alu_z = sz; alu_ovf = (sx[W-1] == sy[W-1]) && (sz[W-1] != sx[W-1]); end
      3'b011: begin sz = sx - sy; alu_z = sz; alu_ovf = (sx[W-1] != sy[W-1]) && (sz[W-1] != sx[W-1]); end
      3'b111: alu_z = {{(W-1){1'b0}}, alu_lt};
      default: begin alu_z = 16'hDEAD; alu_lt = 1'b1; alu_eq = 1'b1; alu_gt = 1'b1; alu_ovf = 1'b1; end
    endcase
  end

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; req_valid = 2'b00; resp_ready = 2'b00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 2'b11; resp_ready = 2'b00;
    #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready_gated got=%b want=00", req_ready); end
    @(negedge clk); #1;
    total++;
    if ({req_ready, resp_valid, resp_z, resp_flags, resp_err, alu_x, alu_y, alu_c} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got rr=%b rv=%b z=%h f=%b e=%b ax=%h ay=%h ac=%b want all 0",
               req_ready, resp_valid, resp_z, resp_flags, resp_err, alu_x, alu_y, alu_c);
    end
    rst = 1'b0; req_valid = 2'b00;
  endtask

  task automatic test_single();
    @(negedge clk);
    req_valid = 2'b01; req0_x = 16'h0013; req0_y = 16'h000B; req0_op = 3'b010;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL single_ready got=%b want=01", req_ready); end
    @(negedge clk); req_valid = 2'b00; #1;
    total++;
    if ({req_ready, resp_valid} !== 4'b0000 || alu_x !== 16'h0013 || alu_y !== 16'h000B || alu_c !== 3'b010) begin
      bad++; $display("FAIL single_exec got rr=%b rv=%b ax=%h ay=%h ac=%b want 00 00 0013 000b 010",
                      req_ready, resp_valid, alu_x, alu_y, alu_c);
    end
    @(negedge clk); #1;
    total++;
    if (resp_valid !== 2'b01 || resp_z !== 16'h001E || resp_flags !== 4'b0010 || resp_err !== 1'b0) begin
      bad++; $display("FAIL single_resp got v=%b z=%h f=%b e=%b want 01 001e 0010 0", resp_valid, resp_z, resp_flags, resp_err);
    end
    resp_ready = 2'b01;
    @(negedge clk); resp_ready = 2'b00; #1;
    total++; if (resp_valid !== 2'b00) begin bad++; $display("FAIL single_resp_drop got=%b want=00", resp_valid); end
  endtask

  task automatic test_contention();
    logic [1:0]   exp_g;
    logic [W-1:0] exp_z;
    logic [3:0]   exp_f;
    reset_dut();
    @(negedge clk);
    req_valid = 2'b11; resp_ready = 2'b11;
    req0_x = 16'h0004; req0_y = 16'h0003; req0_op = 3'b011;
    req1_x = 16'h000B; req1_y = 16'h0013; req1_op = 3'b000;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_z = (k % 2 == 0) ? 16'h0001 : 16'h0003;
      exp_f = (k % 2 == 0) ? 4'b0010 : 4'b1000;
      total++; if (req_ready !== exp_g) begin bad++; $display("FAIL contend_grant%0d got=%b want=%b", k, req_ready, exp_g); end
      @(negedge clk); #1;
      total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL contend_exec_ready%0d got=%b want=00", k, req_ready); end
      @(negedge clk); #1;
      total++;
      if (resp_valid !== exp_g || resp_z !== exp_z || resp_flags !== exp_f) begin
        bad++; $display("FAIL contend_resp%0d got v=%b z=%h f=%b want %b %h %b", k, resp_valid, resp_z, resp_flags, exp_g, exp_z, exp_f);
      end
      @(negedge clk); #1;
    end
    req_valid = 2'b00; resp_ready = 2'b00;
  endtask

  task automatic test_backpressure_slt();
    reset_dut();
    @(negedge clk);
    req_valid = 2'b01;
    req0_x = 16'h0001; req0_y = 16'h0002; req0_op = 3'b010;
    req1_x = 16'h000B; req1_y = 16'h0013; req1_op = 3'b111;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL bp_grant0 got=%b want=01", req_ready); end
    @(negedge clk); req_valid = 2'b10; #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL bp_exec_ready got=%b want=00", req_ready); end
    @(negedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (resp_valid !== 2'b01 || resp_z !== 16'h0003 || req_ready !== 2'b00) begin
        bad++; $display("FAIL bp_hold%0d got v=%b z=%h rr=%b want 01 0003 00", i, resp_valid, resp_z, req_ready);
      end
      resp_ready = i[0] ? 2'b10 : 2'b00;   // non-owner ready must be ignored
      @(negedge clk); #1;
    end
    total++; if (resp_valid !== 2'b01) begin bad++; $display("FAIL bp_still_held got=%b want=01", resp_valid); end
    resp_ready = 2'b01;
    @(negedge clk); resp_ready = 2'b00; #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL bp_grant1 got=%b want=10", req_ready); end
    @(negedge clk); req_valid = 2'b00; #1;
    total++; if (alu_c !== 3'b111 || alu_x !== 16'h000B) begin bad++; $display("FAIL slt_exec got c=%b x=%h want 111 000b", alu_c, alu_x); end
    @(negedge clk); #1;
    total++;
    if (resp_valid !== 2'b10 || resp_z !== 16'h0001 || resp_flags !== 4'b1000 || resp_err !== 1'b0) begin
      bad++; $display("FAIL slt_resp got v=%b z=%h f=%b e=%b want 10 0001 1000 0", resp_valid, resp_z, resp_flags, resp_err);
    end
    resp_ready = 2'b10;
    @(negedge clk); resp_ready = 2'b00;
  endtask

  task automatic test_illegal();
    reset_dut();
    @(negedge clk);
    req_valid = 2'b01; req0_x = 16'h0005; req0_y = 16'h0007; req0_op = 3'b101;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL illegal_grant got=%b want=01", req_ready); end
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk); #1;
    total++;
    if (resp_valid !== 2'b01 || resp_z !== 16'h0000 || resp_flags !== 4'b0000 || resp_err !== 1'b1) begin
      bad++; $display("FAIL illegal_resp got v=%b z=%h f=%b e=%b want 01 0000 0000 1", resp_valid, resp_z, resp_flags, resp_err);
    end
    resp_ready = 2'b01;
    @(negedge clk); resp_ready = 2'b00;
  endtask

  task automatic test_reset_midop();
    reset_dut();
    // one req0 op to completion moves the pointer to 1
    @(negedge clk);
    req_valid = 2'b01; req0_x = 16'h0013; req0_y = 16'h000B; req0_op = 3'b010;
    @(negedge clk); req_valid = 2'b00; resp_ready = 2'b01;
    @(negedge clk);
    @(negedge clk); resp_ready = 2'b00;
    // both valid: pointer 1 picks req1
    req_valid = 2'b11; req1_x = 16'h0022; req1_y = 16'h0001; req1_op = 3'b001;
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL midop_grant1 got=%b want=10", req_ready); end
    @(negedge clk); req_valid = 2'b00; rst = 1'b1; #1;
    total++; if ({req_ready, resp_valid} !== 4'b0000) begin bad++; $display("FAIL midop_rst_hs got rr=%b rv=%b want 00 00", req_ready, resp_valid); end
    @(negedge clk); rst = 1'b0; #1;
    total++;
    if ({resp_valid, resp_z, resp_flags, resp_err, alu_x, alu_y, alu_c} !== '0) begin
      bad++; $display("FAIL midop_outputs got rv=%b z=%h f=%b e=%b ax=%h ay=%h ac=%b want all 0",
                      resp_valid, resp_z, resp_flags, resp_err, alu_x, alu_y, alu_c);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total++; if (resp_valid !== 2'b00) begin bad++; $display("FAIL midop_no_resp%0d got=%b want=00", i, resp_valid); end
    end
    req_valid = 2'b11;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL midop_ptr_reset got=%b want=01", req_ready); end
    req_valid = 2'b00;
  endtask

`ifdef ALU_ARB_PERF_CNT_EN
  task automatic test_perf_cnt();
    reset_dut();
    #1;
    total++; if (grant_cnt0 !== '0 || grant_cnt1 !== '0) begin bad++; $display("FAIL perf_clear got %h %h want 0 0", grant_cnt0, grant_cnt1); end
    @(negedge clk);
    req_valid = 2'b11; resp_ready = 2'b11;
    req0_op = 3'b000; req1_op = 3'b001;
    repeat (12) @(negedge clk);
    req_valid = 2'b01;
    repeat (3) @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk); resp_ready = 2'b00; #1;
    total++; if (grant_cnt0 !== 16'd3 || grant_cnt1 !== 16'd2) begin bad++; $display("FAIL perf_counts got %0d %0d want 3 2", grant_cnt0, grant_cnt1); end
  endtask
`endif

  initial begin
    rst = 1'b1; req_valid = 2'b00; resp_ready = 2'b00;
    req0_x = '0; req0_y = '0; req0_op = 3'b000;
    req1_x = '0; req1_y = '0; req1_op = 3'b000;
    test_reset();
    test_single();
    test_contention();
    test_backpressure_slt();
    test_illegal();
    test_reset_midop();
`ifdef ALU_ARB_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
